// File: rtl/aes_dec_round_ctrl.sv
// aes_dec_round_ctrl
//   Sequencer for an iterative AES-128 decryption datapath that runs one round
//   per clock. It selects the round key, loads and enables the state register
//   and gates InvMixColumns. A start/key_ready and out_valid/out_ready
//   handshake connects it to the block wrapper.
//
//   Every output is decoded from registered state only (FSM, round counter and
//   abort flag), so no input reaches an output combinationally.
//
// Parameters
//   NR     number of rounds; the key mux has NR+1 inputs (0..NR)
//   SEL_W  width of key_sel; 2**SEL_W must exceed NR
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   decrypt request
//   key_ready  in   round keys 0..NR valid; must stay high for the whole block
//   out_ready  in   consumer accepts the plaintext
//   busy       out  accept .. plaintext handshake (or abort)
//   key_sel    out  round-key mux select, never above NR
//   ld_state   out  state <= ciphertext ^ key[NR]
//   state_en   out  state register update enable
//   mix_en     out  InvMixColumns enable (0 = bypass)
//   out_valid  out  plaintext valid in the state register
//   abort      out  one-cycle pulse after key_ready dropped mid-block
module aes_dec_round_ctrl #(
    parameter int NR    = 10,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             key_ready,
    input  logic             out_ready,
    output logic             busy,
    output logic [SEL_W-1:0] key_sel,
    output logic             ld_state,
    output logic             state_en,
    output logic             mix_en,
    output logic             out_valid,
    output logic             abort
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_KEY = 3'd1,
        INIT     = 3'd2,
        ROUND    = 3'd3,
        FINAL    = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] rnd_q, rnd_d;
    logic             abort_q, abort_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            abort_q <= abort_d;
        end
    end

    // Next state. The abort flag is registered so the pulse lands in the
    // first IDLE cycle, where state_en is already low.
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        abort_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = key_ready ? INIT : WAIT_KEY;
            end
            // Being in this state is what remembers the request, so start
            // may drop while the keys are still being expanded.
            WAIT_KEY: begin
                if (key_ready) state_d = INIT;
            end
            INIT: begin
                if (!key_ready) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else begin
                    state_d = ROUND;
                    rnd_d   = SEL_W'(NR - 1);
                end
            end
            ROUND: begin
                if (!key_ready) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                    rnd_d   = '0;
                end else if (rnd_q == SEL_W'(1)) begin
                    state_d = FINAL;
                    rnd_d   = '0;
                end else begin
                    rnd_d = rnd_q - SEL_W'(1);
                end
            end
            FINAL: begin
                state_d = DONE;
                if (!key_ready) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end
            end
            // key_ready is irrelevant here: the plaintext is complete. A new
            // request on the handshake cycle goes straight to INIT.
            DONE: begin
                if (out_ready) state_d = (start && key_ready) ? INIT : IDLE;
            end
            default: begin
                state_d = IDLE;
                rnd_d   = '0;
            end
        endcase
    end

    // Moore output decode.
    always_comb begin
        busy      = 1'b0;
        key_sel   = '0;
        ld_state  = 1'b0;
        state_en  = 1'b0;
        mix_en    = 1'b0;
        out_valid = 1'b0;
        abort     = abort_q;
        unique case (state_q)
            IDLE: ;
            WAIT_KEY: busy = 1'b1;
            INIT: begin
                busy     = 1'b1;
                key_sel  = SEL_W'(NR);
                ld_state = 1'b1;
                state_en = 1'b1;
            end
            ROUND: begin
                busy     = 1'b1;
                key_sel  = rnd_q;
                state_en = 1'b1;
                mix_en   = 1'b1;
            end
            FINAL: begin
                busy     = 1'b1;
                state_en = 1'b1;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
module tb_aes_dec_round_ctrl;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       start = 1'b0, key_ready = 1'b0, out_ready = 1'b0;
    logic       busy, ld_state, state_en, mix_en, out_valid, abort;
    logic [3:0] key_sel;

    aes_dec_round_ctrl #(.NR(10), .SEL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_ready(key_ready),
        .out_ready(out_ready), .busy(busy), .key_sel(key_sel),
        .ld_state(ld_state), .state_en(state_en), .mix_en(mix_en),
        .out_valid(out_valid), .abort(abort)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q[$];

    // ---------------- reference AES decryption datapath ----------------
    logic [7:0]   sbox[256];
    logic [7:0]   isbox[256];
    logic [127:0] rk[11];
    logic [127:0] st;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    task automatic build_tables();
        logic [7:0]  inv, b;
        logic [31:0] w[44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                      ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
        for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]}
                    ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // InvShiftRows, InvSubBytes, AddRoundKey, then optional InvMixColumns.
    function automatic logic [127:0] inv_round(input logic [127:0] s,
                                               input logic [127:0] k, input logic mx);
        logic [7:0]   a[16];
        logic [7:0]   b[16];
        logic [7:0]   mc[4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) b[4*c+r] = isbox[a[4*((c-r+4)%4)+r]];
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        o = o ^ k;
        if (mx) begin
            for (int i = 0; i < 16; i++) a[i] = o[127-8*i -: 8];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    b[4*c+r] = 8'h00;
                    for (int j = 0; j < 4; j++) b[4*c+r] ^= gm(a[4*c+j], mc[(j-r+4)%4]);
                end
            for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        end
        return o;
    endfunction

    always @(posedge clk) begin
        if (ld_state)      st <= CT ^ rk[key_sel];
        else if (state_en) st <= inv_round(st, rk[key_sel], mix_en);
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [9:0] mk(input logic b, input logic [3:0] ks, input logic ld,
                                      input logic en, input logic mx, input logic ov,
                                      input logic ab);
        return {b, ks, ld, en, mx, ov, ab};
    endfunction

    function automatic logic [9:0] ctl();
        return {busy, key_sel, ld_state, state_en, mix_en, out_valid, abort};
    endfunction

    // Monitor: pops an expected plaintext on every output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (key_sel > 4'd10 || (ld_state && !state_en)) begin
                errors++;
                $display("FAIL invariant key_sel=%0d ld=%b en=%b", key_sel, ld_state, state_en);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output got %h want none", st);
                end else begin
                    chk("plaintext", st, exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the INIT cycle; walks through to and checks the first DONE cycle.
    task automatic expect_op(input string nm);
        chk({nm, "_init"}, 128'(ctl()), 128'(mk(1, 4'd10, 1, 1, 0, 0, 0)));
        for (int r = 9; r >= 1; r--) begin
            tick();
            chk($sformatf("%s_round%0d", nm, r), 128'(ctl()), 128'(mk(1, 4'(r), 0, 1, 1, 0, 0)));
        end
        tick();
        chk({nm, "_final"}, 128'(ctl()), 128'(mk(1, 4'd0, 0, 1, 0, 0, 0)));
        tick();
        chk({nm, "_done"}, 128'(ctl()), 128'(mk(1, 4'd0, 0, 0, 0, 1, 0)));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        build_tables();
        key_ready = 1'b1;
        out_ready = 1'b1;
        #12;
        chk("reset", 128'(ctl()), 128'(mk(0, 0, 0, 0, 0, 0, 0)));
        rst_n = 1'b1;
        tick();
        chk("idle", 128'(ctl()), 128'(mk(0, 0, 0, 0, 0, 0, 0)));

        // Basic sequence with a one-cycle start pulse.
        start = 1'b1;
        exp_q.push_back(PT);
        tick();
        start = 1'b0;
        expect_op("t1");
        tick();
        chk("t1_idle", 128'(ctl()), 128'(mk(0, 0, 0, 0, 0, 0, 0)));

        // Start while keys are not ready; start drops during the wait.
        key_ready = 1'b0;
        start     = 1'b1;
        exp_q.push_back(PT);
        for (int i = 0; i < 5; i++) begin
            tick();
            start = 1'b0;
            chk($sformatf("t3_wait%0d", i), 128'(ctl()), 128'(mk(1, 0, 0, 0, 0, 0, 0)));
        end
        key_ready = 1'b1;
        tick();
        expect_op("t3");
        tick();

        // key_ready drops in the key_sel=5 cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("t4_ksel5", 128'(ctl()), 128'(mk(1, 4'd5, 0, 1, 1, 0, 0)));
        key_ready = 1'b0;
        tick();
        chk("t4_abort", 128'(ctl()), 128'(mk(0, 0, 0, 0, 0, 0, 1)));
        key_ready = 1'b1;
        tick();
        chk("t4_after", 128'(ctl()), 128'(mk(0, 0, 0, 0, 0, 0, 0)));
        start = 1'b1;
        exp_q.push_back(PT);
        tick();
        start = 1'b0;
        expect_op("t4b");
        tick();

        // Back-pressure in DONE, then back-to-back start on the handshake.
        out_ready = 1'b0;
        start     = 1'b1;
        exp_q.push_back(PT);
        tick();
        start = 1'b0;
        expect_op("t5");
        chk("t5_hold_st0", st, PT);
        for (int i = 1; i < 7; i++) begin
            tick();
            chk($sformatf("t5_hold%0d", i), 128'(ctl()), 128'(mk(1, 0, 0, 0, 0, 1, 0)));
            chk($sformatf("t5_hold_st%0d", i), st, PT);
        end
        out_ready = 1'b1;
        start     = 1'b1;
        exp_q.push_back(PT);
        tick();
        start = 1'b0;
        expect_op("t5b");
        tick();
        chk("t5_idle", 128'(ctl()), 128'(mk(0, 0, 0, 0, 0, 0, 0)));

        // Asynchronous reset in the middle of ROUND.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("t6_round7", 128'(ctl()), 128'(mk(1, 4'd7, 0, 1, 1, 0, 0)));
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async", 128'(ctl()), 128'(mk(0, 0, 0, 0, 0, 0, 0)));
        start = 1'b1;
        repeat (2) tick();
        chk("t6_hold", 128'(ctl()), 128'(mk(0, 0, 0, 0, 0, 0, 0)));
        start = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        chk("t6_release", 128'(ctl()), 128'(mk(0, 0, 0, 0, 0, 0, 0)));
        repeat (3) tick();

        chk("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
